// File: rtl/alu_muldiv_seq.sv
// alu_muldiv_seq: multi-cycle multiply/divide unit with HI/LO registers.
// Handles mult/multu/div/divu (iterative, WIDTH+1 cycles) and
// mfhi/mflo/mthi/mtlo (single cycle) behind a start/busy/done handshake.
// Optional feature macro: ALU_DIV_EN compiles in the restoring divider;
// without it div/divu behave as unknown funct codes.
module alu_muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [5:0]       ALU_control,
    input  logic [WIDTH-1:0] rs_content,
    input  logic [WIDTH-1:0] rt_content,
    output logic [WIDTH-1:0] ALU_result,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;

    localparam int              CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX
    } state_t;

    state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q;

    // Magnitude of an operand; unsigned ops pass through untouched.
    function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] v,
                                             input logic sgn);
        logic signed [WIDTH-1:0] n;
        n   = -v;
        mag = (sgn && v[WIDTH-1]) ? n : v;
    endfunction

    // Conditional two's-complement negation of a single word.
    function automatic logic [WIDTH-1:0] neg_word(input logic [WIDTH-1:0] v,
                                                  input logic en);
        neg_word = en ? -v : v;
    endfunction

    // Conditional two's-complement negation of the double-width product.
    function automatic logic [2*WIDTH-1:0] neg_wide(input logic [2*WIDTH-1:0] v,
                                                    input logic en);
        neg_wide = en ? -v : v;
    endfunction

    logic is_mul, is_div, op_signed, accept, go_run;

    // Request decode; the divider codes only count as iterative when built in.
    always_comb begin
        is_mul = (ALU_control == F_MULT) || (ALU_control == F_MULTU);
        is_div = 1'b0;
`ifdef ALU_DIV_EN
        is_div = (ALU_control == F_DIV) || (ALU_control == F_DIVU);
`endif
        op_signed = ~ALU_control[0];
        accept    = start && (state_q == S_IDLE);
        go_run    = accept && (is_mul || is_div);
    end

    // Iteration state: running product, or {remainder, quotient} when dividing.
    logic [2*WIDTH-1:0] prod_q, step_nxt;
    logic [WIDTH-1:0]   opb_q;
    logic               neg_lo_q;
    logic [WIDTH:0]     mul_sum;
`ifdef ALU_DIV_EN
    logic               op_div_q, neg_hi_q;
    logic [WIDTH-1:0]   rs_q;
    logic [WIDTH:0]     div_trial;
`endif

    // One shift-add (or restoring-subtract) step per RUN cycle.
    always_comb begin
        mul_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, (prod_q[0] ? opb_q : '0)};
        step_nxt = {mul_sum, prod_q[WIDTH-1:1]};
`ifdef ALU_DIV_EN
        div_trial = prod_q[2*WIDTH-1:WIDTH-1] - {1'b0, opb_q};
        if (op_div_q) begin
            if (div_trial[WIDTH])
                step_nxt = {prod_q[2*WIDTH-2:0], 1'b0};
            else
                step_nxt = {div_trial[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b1};
        end
`endif
    end

    // Operand capture at acceptance, then iterate; data path carries no reset.
    always_ff @(posedge clk) begin
        if (go_run) begin
            neg_lo_q <= op_signed && (rs_content[WIDTH-1] ^ rt_content[WIDTH-1]);
            prod_q   <= {{WIDTH{1'b0}}, (is_div ? mag(rs_content, op_signed)
                                                : mag(rt_content, op_signed))};
            opb_q    <= is_div ? mag(rt_content, op_signed) : mag(rs_content, op_signed);
`ifdef ALU_DIV_EN
            op_div_q <= is_div;
            neg_hi_q <= op_signed && rs_content[WIDTH-1];
            rs_q     <= rs_content;
`endif
        end else if (state_q == S_RUN) begin
            prod_q <= step_nxt;
        end
    end

    logic [2*WIDTH-1:0] wide_res;
    logic [WIDTH-1:0]   fix_hi, fix_lo;
    logic               fix_dbz;

    // Sign correction and divide special cases for the final HI/LO write.
    always_comb begin
        wide_res = neg_wide(prod_q, neg_lo_q);
        fix_hi   = wide_res[2*WIDTH-1:WIDTH];
        fix_lo   = wide_res[WIDTH-1:0];
        fix_dbz  = 1'b0;
`ifdef ALU_DIV_EN
        if (op_div_q) begin
            if (opb_q == '0) begin
                fix_lo  = '1;
                fix_hi  = rs_q;
                fix_dbz = 1'b1;
            end else begin
                fix_lo = neg_word(prod_q[WIDTH-1:0], neg_lo_q);
                fix_hi = neg_word(prod_q[2*WIDTH-1:WIDTH], neg_hi_q);
            end
        end
`endif
    end

    // Next-state logic: IDLE -> RUN for WIDTH cycles -> FIX -> IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (go_run) state_d = S_RUN;
            S_RUN:   if (cnt_q == CNT_LAST) state_d = S_FIX;
            S_FIX:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State register and iteration counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_RUN && cnt_q != CNT_LAST)
                cnt_q <= cnt_q + 1'b1;
            else
                cnt_q <= '0;
        end
    end

    assign busy = (state_q != S_IDLE);

    // Architectural registers: single-cycle ops at acceptance, iterative ops in FIX.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ALU_result  <= '0;
            hi          <= '0;
            lo          <= '0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept && !go_run) begin
                done        <= 1'b1;
                div_by_zero <= 1'b0;
                case (ALU_control)
                    F_MFHI:  ALU_result <= hi;
                    F_MFLO:  ALU_result <= lo;
                    F_MTHI:  hi <= rs_content;
                    F_MTLO:  lo <= rs_content;
                    default: ;
                endcase
            end else if (state_q == S_FIX) begin
                hi          <= fix_hi;
                lo          <= fix_lo;
                div_by_zero <= fix_dbz;
                done        <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// tb_alu_muldiv_seq: directed vectors with hand-computed results for alu_muldiv_seq.
// Divide expectations follow the ALU_DIV_EN build option.
module tb_alu_muldiv_seq;

    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_ADD   = 6'b100000;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [5:0]  alu_control;
    logic [31:0] rs, rt;
    logic [31:0] alu_result, hi, lo;
    logic        busy, done, div_by_zero;

    int nvec = 0;
    int nmis = 0;

    alu_muldiv_seq #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .ALU_control (alu_control),
        .rs_content  (rs),
        .rt_content  (rt),
        .ALU_result  (alu_result),
        .hi          (hi),
        .lo          (lo),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one request and wait (bounded) for done; edges counts clock edges after acceptance.
    task automatic do_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int edges, output int bcnt, output bit moved);
        logic [31:0] h0, l0;
        @(negedge clk);
        h0 = hi; l0 = lo;
        alu_control = op; rs = a; rt = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        edges = 0; bcnt = 0; moved = 1'b0;
        while (!done && edges < 100) begin
            if (busy) bcnt++;
            if (hi !== h0 || lo !== l0) moved = 1'b1;
            @(negedge clk);
            edges++;
        end
        chk("done_seen", {63'd0, done}, 64'd1);
    endtask

    int          e, b, nd;
    bit          mv;
    logic [31:0] ph, pl;

    initial begin
        rst = 1'b1; start = 1'b0; alu_control = '0; rs = '0; rt = '0;
        #12;
        chk("rst_result", {32'd0, alu_result}, 64'd0);
        chk("rst_hi",     {32'd0, hi}, 64'd0);
        chk("rst_lo",     {32'd0, lo}, 64'd0);
        chk("rst_busy",   {63'd0, busy}, 64'd0);
        chk("rst_done",   {63'd0, done}, 64'd0);
        chk("rst_dbz",    {63'd0, div_by_zero}, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // mult -3 * 5
        do_op(F_MULT, 32'hFFFF_FFFD, 32'd5, e, b, mv);
        chk("mult_latency", 64'(e), 64'd33);
        chk("mult_busy_cycles", 64'(b), 64'd33);
        chk("mult_hilo_hidden", {63'd0, mv}, 64'd0);
        chk("mult_busy_at_done", {63'd0, busy}, 64'd0);
        chk("mult_hi", {32'd0, hi}, 64'hFFFF_FFFF);
        chk("mult_lo", {32'd0, lo}, 64'hFFFF_FFF1);
        chk("mult_dbz", {63'd0, div_by_zero}, 64'd0);
        @(negedge clk);
        chk("done_pulse_width", {63'd0, done}, 64'd0);

        // multu 0xFFFFFFFF squared
        do_op(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, e, b, mv);
        chk("multu_hi", {32'd0, hi}, 64'hFFFF_FFFE);
        chk("multu_lo", {32'd0, lo}, 64'h0000_0001);

        // mult 7 * 6 (positive)
        do_op(F_MULT, 32'd7, 32'd6, e, b, mv);
        chk("mult_pos_hi", {32'd0, hi}, 64'd0);
        chk("mult_pos_lo", {32'd0, lo}, 64'd42);

        // div -7 / 2
        ph = hi; pl = lo;
        do_op(F_DIV, 32'hFFFF_FFF9, 32'd2, e, b, mv);
`ifdef ALU_DIV_EN
        chk("div_latency", 64'(e), 64'd33);
        chk("div_lo", {32'd0, lo}, 64'hFFFF_FFFD);
        chk("div_hi", {32'd0, hi}, 64'hFFFF_FFFF);
        chk("div_dbz", {63'd0, div_by_zero}, 64'd0);

        // div 7 / -2
        do_op(F_DIV, 32'd7, 32'hFFFF_FFFE, e, b, mv);
        chk("div_negdvsr_lo", {32'd0, lo}, 64'hFFFF_FFFD);
        chk("div_negdvsr_hi", {32'd0, hi}, 64'd1);

        // div MIN / -1
        do_op(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, e, b, mv);
        chk("div_min_lo", {32'd0, lo}, 64'h8000_0000);
        chk("div_min_hi", {32'd0, hi}, 64'd0);
        chk("div_min_dbz", {63'd0, div_by_zero}, 64'd0);

        // divu 100 / 0
        do_op(F_DIVU, 32'd100, 32'd0, e, b, mv);
        chk("divz_lo", {32'd0, lo}, 64'hFFFF_FFFF);
        chk("divz_hi", {32'd0, hi}, 64'd100);
        chk("divz_dbz", {63'd0, div_by_zero}, 64'd1);
`else
        chk("nodiv_latency", 64'(e), 64'd0);
        chk("nodiv_busy_cycles", 64'(b), 64'd0);
        chk("nodiv_hi", {32'd0, hi}, {32'd0, ph});
        chk("nodiv_lo", {32'd0, lo}, {32'd0, pl});

        // divu 100 / 0 without the divider
        do_op(F_DIVU, 32'd100, 32'd0, e, b, mv);
        chk("nodivz_latency", 64'(e), 64'd0);
        chk("nodivz_hi", {32'd0, hi}, {32'd0, ph});
        chk("nodivz_lo", {32'd0, lo}, {32'd0, pl});
        chk("nodivz_dbz", {63'd0, div_by_zero}, 64'd0);
`endif

        // mthi then mfhi
        do_op(F_MTHI, 32'h0000_1234, 32'd0, e, b, mv);
        chk("mthi_latency", 64'(e), 64'd0);
        chk("mthi_busy_cycles", 64'(b), 64'd0);
        chk("mthi_hi", {32'd0, hi}, 64'h1234);
        do_op(F_MFHI, 32'd0, 32'd0, e, b, mv);
        chk("mfhi_latency", 64'(e), 64'd0);
        chk("mfhi_result", {32'd0, alu_result}, 64'h1234);

        // mtlo then mflo
        do_op(F_MTLO, 32'h0000_ABCD, 32'd0, e, b, mv);
        chk("mtlo_lo", {32'd0, lo}, 64'hABCD);
        chk("mtlo_hi_kept", {32'd0, hi}, 64'h1234);
        do_op(F_MFLO, 32'd0, 32'd0, e, b, mv);
        chk("mflo_result", {32'd0, alu_result}, 64'hABCD);

        // unknown funct: done only
        do_op(F_ADD, 32'h5555_5555, 32'h1, e, b, mv);
        chk("unk_latency", 64'(e), 64'd0);
        chk("unk_hi", {32'd0, hi}, 64'h1234);
        chk("unk_lo", {32'd0, lo}, 64'hABCD);
        chk("unk_dbz", {63'd0, div_by_zero}, 64'd0);

        // second start during a mult is ignored
        @(negedge clk);
        alu_control = F_MULT; rs = 32'd3; rt = 32'd4; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        alu_control = F_MTHI; rs = 32'hDEAD; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        nd = 0;
        for (int i = 0; i < 60; i++) begin
            if (done) nd++;
            @(negedge clk);
        end
        chk("ignore_done_count", 64'(nd), 64'd1);
        chk("ignore_hi", {32'd0, hi}, 64'd0);
        chk("ignore_lo", {32'd0, lo}, 64'd12);

        // reset during a mult aborts it
        @(negedge clk);
        alu_control = F_MULT; rs = 32'd5; rt = 32'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_hi", {32'd0, hi}, 64'd0);
        chk("abort_lo", {32'd0, lo}, 64'd0);
        chk("abort_busy", {63'd0, busy}, 64'd0);
        chk("abort_result", {32'd0, alu_result}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        nd = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) nd++;
            @(negedge clk);
        end
        chk("abort_no_done", 64'(nd), 64'd0);

        // fresh mult after abort, then back-to-back mflo in the done cycle
        do_op(F_MULTU, 32'h0001_0001, 32'h0001_0001, e, b, mv);
        chk("fresh_latency", 64'(e), 64'd33);
        chk("fresh_hi", {32'd0, hi}, 64'h1);
        chk("fresh_lo", {32'd0, lo}, 64'h0002_0001);
        alu_control = F_MFLO; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("b2b_done", {63'd0, done}, 64'd1);
        chk("b2b_result", {32'd0, alu_result}, 64'h0002_0001);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
